// File: rtl/vc_queue_flex.sv
// vc_queue_flex: val/rdy queue of any depth/width with static normal/pipe/bypass mode, flush, count and almost_full.
//   Ports: clk, reset (sync, active-high), clear (sync flush), enq_val/enq_rdy/enq_msg (producer),
//   deq_val/deq_rdy/deq_msg (consumer), count (stored entries), almost_full (count >= p_afull_thresh),
//   hwm (high-water mark since last reset/clear; built only with VC_QUEUE_FLEX_HWM_EN defined, else tied 0).
//   p_type: bit0 = pipe, bit1 = bypass.
module vc_queue_flex #(
  parameter int p_type = 0,
  parameter int p_msg_nbits = 32,
  parameter int p_num_msgs = 4,
  parameter int p_afull_thresh = 3,
  localparam int c_cnt_nbits = $clog2(p_num_msgs + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   enq_val,
  output logic                   enq_rdy,
  input  logic [p_msg_nbits-1:0] enq_msg,
  output logic                   deq_val,
  input  logic                   deq_rdy,
  output logic [p_msg_nbits-1:0] deq_msg,
  output logic [c_cnt_nbits-1:0] count,
  output logic                   almost_full,
  output logic [c_cnt_nbits-1:0] hwm
);
  localparam int c_ptr_nbits = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1;
  localparam bit c_pipe = (p_type % 2) == 1;
  localparam bit c_bypass = ((p_type / 2) % 2) == 1;
  localparam logic [c_ptr_nbits-1:0] c_last = c_ptr_nbits'(p_num_msgs - 1);
  localparam logic [c_cnt_nbits-1:0] c_full = c_cnt_nbits'(p_num_msgs);
  logic [p_msg_nbits-1:0] mem_q [p_num_msgs];
  logic [p_msg_nbits-1:0] mem_d [p_num_msgs];
  logic [c_ptr_nbits-1:0] enq_ptr_q, enq_ptr_d, deq_ptr_q, deq_ptr_d;
  logic [c_cnt_nbits-1:0] count_q, count_d;
  logic full, empty, do_enq, do_deq, do_byp, st_enq, st_deq;
  // wrap at the configured depth, not at a power of two
  function automatic logic [c_ptr_nbits-1:0] nxt(input logic [c_ptr_nbits-1:0] p);
    return (p == c_last) ? '0 : p + 1'b1;
  endfunction
  assign full = count_q == c_full;
  assign empty = count_q == '0;
  assign enq_rdy = ~clear & (~full | (c_pipe & deq_rdy));
  // bypass visibility is held off during reset so a pending enq is not presented
  assign deq_val = ~clear & ~reset & (~empty | (c_bypass & enq_val));
  assign do_enq = enq_val & enq_rdy;
  assign do_deq = deq_val & deq_rdy;
  // a bypassed message never touches storage, pointers or count
  assign do_byp = c_bypass & empty & do_enq & do_deq;
  assign st_enq = do_enq & ~do_byp;
  assign st_deq = do_deq & ~do_byp;
  assign deq_msg = (c_bypass & empty) ? enq_msg : mem_q[deq_ptr_q];
  assign count = count_q;
  assign almost_full = count_q >= c_cnt_nbits'(p_afull_thresh);
  always_comb begin
    mem_d = mem_q;
    if (st_enq) mem_d[enq_ptr_q] = enq_msg;
  end
  assign enq_ptr_d = clear ? '0 : st_enq ? nxt(enq_ptr_q) : enq_ptr_q;
  assign deq_ptr_d = clear ? '0 : st_deq ? nxt(deq_ptr_q) : deq_ptr_q;
  assign count_d = clear ? '0 : count_q + c_cnt_nbits'(st_enq) - c_cnt_nbits'(st_deq);
  always_ff @(posedge clk) begin
    if (reset) begin
      enq_ptr_q <= '0;
      deq_ptr_q <= '0;
      count_q <= '0;
    end else begin
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
`ifdef VC_QUEUE_FLEX_HWM_EN
  logic [c_cnt_nbits-1:0] hwm_q, hwm_d;
  assign hwm_d = clear ? '0 : (count_d > hwm_q) ? count_d : hwm_q;
  always_ff @(posedge clk) begin
    if (reset) hwm_q <= '0;
    else hwm_q <= hwm_d;
  end
  assign hwm = hwm_q;
`else
  assign hwm = '0;
`endif
  a_known: assert property (@(posedge clk) disable iff (reset) !$isunknown({enq_val, deq_rdy, clear}));
  a_count: assert property (@(posedge clk) disable iff (reset) count_q <= c_full);
endmodule

// File: tb/tb_vc_queue_flex.sv
// tb_vc_queue_flex: scoreboard bench for vc_queue_flex in normal, pipe+bypass and depth-1 configurations.
module tb_vc_queue_flex;
`ifdef VC_QUEUE_FLEX_HWM_EN
  localparam bit hwm_on = 1'b1;
`else
  localparam bit hwm_on = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic a_clear = 0, a_enq_val = 0, a_deq_rdy = 0, a_enq_rdy, a_deq_val, a_af;
  logic [7:0] a_enq_msg = 0, a_deq_msg;
  logic [1:0] a_count, a_hwm;
  logic b_clear = 0, b_enq_val = 0, b_deq_rdy = 0, b_enq_rdy, b_deq_val, b_af;
  logic [7:0] b_enq_msg = 0, b_deq_msg;
  logic [1:0] b_count, b_hwm;
  logic c_clear = 0, c_enq_val = 0, c_deq_rdy = 0, c_enq_rdy, c_deq_val, c_af;
  logic [7:0] c_enq_msg = 0, c_deq_msg;
  logic [0:0] c_count, c_hwm;
  vc_queue_flex #(.p_type(0), .p_msg_nbits(8), .p_num_msgs(3), .p_afull_thresh(2)) u_a (
    .clk(clk), .reset(reset), .clear(a_clear), .enq_val(a_enq_val), .enq_rdy(a_enq_rdy),
    .enq_msg(a_enq_msg), .deq_val(a_deq_val), .deq_rdy(a_deq_rdy), .deq_msg(a_deq_msg),
    .count(a_count), .almost_full(a_af), .hwm(a_hwm));
  vc_queue_flex #(.p_type(3), .p_msg_nbits(8), .p_num_msgs(2), .p_afull_thresh(2)) u_b (
    .clk(clk), .reset(reset), .clear(b_clear), .enq_val(b_enq_val), .enq_rdy(b_enq_rdy),
    .enq_msg(b_enq_msg), .deq_val(b_deq_val), .deq_rdy(b_deq_rdy), .deq_msg(b_deq_msg),
    .count(b_count), .almost_full(b_af), .hwm(b_hwm));
  vc_queue_flex #(.p_type(0), .p_msg_nbits(8), .p_num_msgs(1), .p_afull_thresh(1)) u_c (
    .clk(clk), .reset(reset), .clear(c_clear), .enq_val(c_enq_val), .enq_rdy(c_enq_rdy),
    .enq_msg(c_enq_msg), .deq_val(c_deq_val), .deq_rdy(c_deq_rdy), .deq_msg(c_deq_msg),
    .count(c_count), .almost_full(c_af), .hwm(c_hwm));
  int n_vec = 0;
  int n_fail = 0;
  int a_cnt = 0;
  logic [7:0] exp_a[$], exp_b[$], exp_c[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic pop_chk(input string nm, input logic [7:0] act, inout logic [7:0] q[$]);
    if (q.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s: got unexpected %0h expected nothing", nm, act);
    end else chk(nm, 32'(act), 32'(q.pop_front()));
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      if (a_deq_val && a_deq_rdy) pop_chk("a_deq_msg", a_deq_msg, exp_a);
      if (b_deq_val && b_deq_rdy) pop_chk("b_deq_msg", b_deq_msg, exp_b);
      if (c_deq_val && c_deq_rdy) pop_chk("c_deq_msg", c_deq_msg, exp_c);
    end
  end
  // depth-3 normal queue: expected handshake/occupancy follow a simple occupancy counter
  task automatic a_cycle(input logic ev, input logic [7:0] m, input logic dr);
    logic rdy_e, val_e;
    @(posedge clk); #1;
    a_enq_val = ev; a_enq_msg = m; a_deq_rdy = dr;
    rdy_e = a_cnt < 3;
    val_e = a_cnt > 0;
    if (ev && rdy_e) exp_a.push_back(m);
    @(negedge clk);
    chk("a_enq_rdy", 32'(a_enq_rdy), 32'(rdy_e));
    chk("a_deq_val", 32'(a_deq_val), 32'(val_e));
    chk("a_count", 32'(a_count), 32'(a_cnt));
    chk("a_almost_full", 32'(a_af), 32'(a_cnt >= 2));
    a_cnt = a_cnt + int'(ev && rdy_e) - int'(dr && val_e);
  endtask
  task automatic b_cycle(input logic ev, input logic [7:0] m, input logic dr,
                         input logic rdy_e, input logic val_e, input int cnt_e, input logic af_e);
    @(posedge clk); #1;
    b_enq_val = ev; b_enq_msg = m; b_deq_rdy = dr;
    if (ev && rdy_e) exp_b.push_back(m);
    @(negedge clk);
    chk("b_enq_rdy", 32'(b_enq_rdy), 32'(rdy_e));
    chk("b_deq_val", 32'(b_deq_val), 32'(val_e));
    chk("b_count", 32'(b_count), 32'(cnt_e));
    chk("b_almost_full", 32'(b_af), 32'(af_e));
  endtask
  task automatic c_cycle(input logic ev, input logic [7:0] m, input logic dr,
                         input logic rdy_e, input logic val_e, input int cnt_e);
    @(posedge clk); #1;
    c_enq_val = ev; c_enq_msg = m; c_deq_rdy = dr;
    if (ev && rdy_e) exp_c.push_back(m);
    @(negedge clk);
    chk("c_enq_rdy", 32'(c_enq_rdy), 32'(rdy_e));
    chk("c_deq_val", 32'(c_deq_val), 32'(val_e));
    chk("c_count", 32'(c_count), 32'(cnt_e));
    chk("c_almost_full", 32'(c_af), 32'(cnt_e >= 1));
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    b_enq_val = 1; b_enq_msg = 8'h11;
    @(negedge clk);
    chk("rst_a_enq_rdy", 32'(a_enq_rdy), 1);
    chk("rst_a_deq_val", 32'(a_deq_val), 0);
    chk("rst_a_count", 32'(a_count), 0);
    chk("rst_a_almost_full", 32'(a_af), 0);
    chk("rst_a_hwm", 32'(a_hwm), 0);
    chk("rst_b_deq_val_bypass", 32'(b_deq_val), 0);
    @(posedge clk); #1;
    reset = 0; b_enq_val = 0;
    // fill depth 3, refuse a fourth, then drain in order
    a_cycle(1, 8'hA1, 0);
    a_cycle(1, 8'hA2, 0);
    a_cycle(1, 8'hA3, 0);
    a_cycle(1, 8'hEE, 0);
    a_cycle(0, 8'h00, 1);
    a_cycle(0, 8'h00, 1);
    a_cycle(0, 8'h00, 1);
    a_cycle(0, 8'h00, 0);
    // seven interleaved transfers wrap both pointers past slot 2
    a_cycle(1, 8'hB0, 0);
    for (int i = 1; i < 7; i++) a_cycle(1, 8'hB0 + 8'(i), 1);
    a_cycle(0, 8'h00, 1);
    a_cycle(0, 8'h00, 0);
    // flush at count 2 while a transfer is offered both ways
    a_cycle(1, 8'hC1, 0);
    a_cycle(1, 8'hC2, 0);
    chk("a_hwm_before_clear", 32'(a_hwm), hwm_on ? 32'd3 : 32'd0);
    @(posedge clk); #1;
    a_clear = 1; a_enq_val = 1; a_enq_msg = 8'hCC; a_deq_rdy = 1;
    exp_a.delete();
    @(negedge clk);
    chk("clr_a_enq_rdy", 32'(a_enq_rdy), 0);
    chk("clr_a_deq_val", 32'(a_deq_val), 0);
    chk("clr_a_count", 32'(a_count), 2);
    @(posedge clk); #1;
    a_clear = 0; a_enq_val = 0;
    @(negedge clk);
    chk("post_clr_a_count", 32'(a_count), 0);
    chk("post_clr_a_deq_val", 32'(a_deq_val), 0);
    chk("post_clr_a_hwm", 32'(a_hwm), 0);
    a_cnt = 0;
    a_cycle(1, 8'hD1, 0);
    a_cycle(0, 8'h00, 1);
    a_cycle(0, 8'h00, 0);
    // pipe+bypass depth 2: fill, refuse while full without deq, then stream through full
    b_cycle(1, 8'h01, 0, 1, 1, 0, 0);
    b_cycle(1, 8'h02, 0, 1, 1, 1, 0);
    b_cycle(1, 8'hEE, 0, 0, 1, 2, 1);
    b_cycle(1, 8'h03, 1, 1, 1, 2, 1);
    b_cycle(1, 8'h04, 1, 1, 1, 2, 1);
    b_cycle(1, 8'h05, 1, 1, 1, 2, 1);
    b_cycle(1, 8'h06, 1, 1, 1, 2, 1);
    b_cycle(0, 8'h00, 1, 1, 1, 2, 1);
    b_cycle(0, 8'h00, 1, 1, 1, 1, 0);
    // empty bypass: message appears on deq in the same cycle
    b_cycle(1, 8'h5A, 1, 1, 1, 0, 0);
    chk("b_bypass_msg", 32'(b_deq_msg), 32'h5A);
    b_cycle(0, 8'h00, 0, 1, 0, 0, 0);
    // depth 1: both pointers pinned at slot 0
    c_cycle(1, 8'hE1, 0, 1, 0, 0);
    c_cycle(1, 8'hEE, 0, 0, 1, 1);
    chk("c_hwm_full", 32'(c_hwm), hwm_on ? 32'd1 : 32'd0);
    c_cycle(0, 8'h00, 1, 0, 1, 1);
    c_cycle(0, 8'h00, 0, 1, 0, 0);
    chk("c_hwm_hold", 32'(c_hwm), hwm_on ? 32'd1 : 32'd0);
    c_cycle(1, 8'hE2, 0, 1, 0, 0);
    c_cycle(0, 8'h00, 1, 0, 1, 1);
    c_cycle(0, 8'h00, 0, 1, 0, 0);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("rst2_c_hwm", 32'(c_hwm), 0);
    chk("rst2_c_count", 32'(c_count), 0);
    chk("rst2_c_enq_rdy", 32'(c_enq_rdy), 1);
    chk("a_sb_drained", 32'(exp_a.size()), 0);
    chk("b_sb_drained", 32'(exp_b.size()), 0);
    chk("c_sb_drained", 32'(exp_c.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
